// File: rtl/ram_bist_pkg.sv
// RAM BIST shared types: FSM states, pattern modes
// and the write/expect pattern generator.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [1:0] MODE_INCR  = 2'd0;
   localparam logic [1:0] MODE_CONST = 2'd1;
   localparam logic [1:0] MODE_WALK  = 2'd2;
   localparam logic [1:0] MODE_CHK   = 2'd3;

   // Pattern computed at 32 bits, masked to dw bits.
   function automatic logic [31:0] bist_pattern(
      input logic [1:0]  mode,
      input logic [31:0] seed,
      input logic [31:0] addr,
      input int unsigned dw
   );
      logic [31:0] p;
      logic [31:0] mask;
      mask = (dw >= 32) ? 32'hFFFF_FFFF
                        : ((32'd1 << dw) - 32'd1);
      unique case (mode)
         MODE_INCR:  p = seed + addr;
         MODE_CONST: p = seed;
         MODE_WALK:  p = 32'd1 << (addr % dw);
         MODE_CHK:   p = addr[0] ? ~seed : seed;
         default:    p = 32'd0;
      endcase
      return p & mask;
   endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// RAM BIST compare path: read-valid delay line,
// data comparator and sticky error bookkeeping.
module ram_bist_chk
   import ram_bist_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_vld,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [1:0]        i_mode,
   input  logic [DATA_W-1:0] i_seed,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_err,
   output logic [15:0]       o_err_cnt,
   output logic [ADDR_W-1:0] o_err_addr
);

   logic              r_vld [RD_LAT];
   logic [ADDR_W-1:0] r_adr [RD_LAT];
   logic [DATA_W-1:0] w_exp;
   logic              w_miss;

   assign w_exp = DATA_W'(bist_pattern(i_mode,
                     32'(i_seed),
                     32'(r_adr[RD_LAT-1]),
                     DATA_W));
   assign w_miss = r_vld[RD_LAT-1]
                && (i_rd_data != w_exp);

   // Delay read valid/address to line up with RAM data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_vld[i] <= 1'b0;
            r_adr[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_vld;
         r_adr[0] <= i_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_adr[i] <= r_adr[i-1];
         end
      end
   end

   // Sticky error flag, saturating count, first address.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         o_err      <= 1'b0;
         o_err_cnt  <= '0;
         o_err_addr <= '0;
      end else if (w_miss) begin
         o_err <= 1'b1;
         if (o_err_cnt != 16'hFFFF)
            o_err_cnt <= o_err_cnt + 16'd1;
         if (!o_err)
            o_err_addr <= r_adr[RD_LAT-1];
      end
   end

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST controller: write a pattern over the whole
// RAM, read it back, and report miscompares.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   output logic              ram_wr_en,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] err_addr
);

   localparam logic [ADDR_W-1:0] A_LAST = '1;
   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_t            r_state;
   logic [1:0]        r_mode;
   logic [DATA_W-1:0] r_seed;
   logic [2:0]        r_lat;
   logic [ADDR_W-1:0] w_addr_nx;
   logic              w_start_acc;

   assign w_addr_nx   = ram_addr + 1'b1;
   assign w_start_acc = (r_state == S_IDLE) && start;

   function automatic logic [DATA_W-1:0] pat(
      input logic [1:0]        m,
      input logic [DATA_W-1:0] s,
      input logic [ADDR_W-1:0] a
   );
      return DATA_W'(bist_pattern(m, 32'(s),
                        32'(a), DATA_W));
   endfunction

   // Sequencer: write sweep, read sweep, drain, done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= '0;
         r_seed      <= '0;
         r_lat       <= '0;
         ram_wr_en   <= 1'b0;
         ram_rd_en   <= 1'b0;
         ram_addr    <= '0;
         ram_wr_data <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode      <= mode;
                  r_seed      <= seed;
                  r_state     <= S_WRITE;
                  busy        <= 1'b1;
                  ram_wr_en   <= 1'b1;
                  ram_addr    <= '0;
                  ram_wr_data <= pat(mode, seed, '0);
               end
            end
            S_WRITE: begin
               if (ram_addr == A_LAST) begin
                  ram_wr_en   <= 1'b0;
                  ram_wr_data <= '0;
                  ram_rd_en   <= 1'b1;
                  ram_addr    <= '0;
                  r_state     <= S_READ;
               end else begin
                  ram_addr    <= w_addr_nx;
                  ram_wr_data <= pat(r_mode, r_seed,
                                     w_addr_nx);
               end
            end
            S_READ: begin
               if (ram_addr == A_LAST) begin
                  ram_rd_en <= 1'b0;
                  ram_addr  <= '0;
                  r_lat     <= '0;
                  r_state   <= S_DRAIN;
               end else begin
                  ram_addr <= w_addr_nx;
               end
            end
            S_DRAIN: begin
               if (r_lat == LAT_LAST) begin
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_lat <= r_lat + 3'd1;
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   ram_bist_chk #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_start_acc),
      .i_vld      (ram_rd_en),
      .i_addr     (ram_addr),
      .i_mode     (r_mode),
      .i_seed     (r_seed),
      .i_rd_data  (ram_rd_data),
      .o_err      (err),
      .o_err_cnt  (err_cnt),
      .o_err_addr (err_addr)
   );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RD_LAT=1 and RD_LAT=3
// instances, each with its own RAM model and monitor.
module tb_ram_bist_ctrl;

   typedef struct {
      int         addr;
      logic [7:0] data;
      logic       err;
      int         cnt;
      logic       gt0;
      int         eaddr;
      int         busy;
   } run_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n   [2];
   logic        start   [2];
   logic [1:0]  mode    [2];
   logic [7:0]  seed    [2];
   logic        wr_en   [2];
   logic        rd_en   [2];
   logic [4:0]  addr    [2];
   logic [7:0]  wr_data [2];
   logic [7:0]  rd_data [2];
   logic        busy    [2];
   logic        done    [2];
   logic        err     [2];
   logic [15:0] err_cnt [2];
   logic [4:0]  err_addr[2];
   int          fault   [2];
   int          mlat    [2];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // Model read: optional stuck bit0 at addr 5 or all bits inverted.
   function automatic logic [7:0] rdfn(input logic [7:0] d,
                                       input int f,
                                       input logic [4:0] a);
      logic [7:0] r;
      r = d;
      if (f == 1 && a == 5'd5) r[0] = 1'b1;
      if (f == 2) r = ~r;
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int LAT = (g == 0) ? 1 : 3;
      run_t       exp_q[$];
      run_t       r;
      logic [7:0] mem  [32];
      logic [7:0] pipe [4];
      logic [7:0] lastw[32];
      int         bcnt = 0;
      logic       ovl = 1'b0;

      ram_bist_ctrl #(
         .DATA_W (8),
         .ADDR_W (5),
         .RD_LAT (LAT)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n[g]),
         .start       (start[g]),
         .mode        (mode[g]),
         .seed        (seed[g]),
         .ram_wr_en   (wr_en[g]),
         .ram_rd_en   (rd_en[g]),
         .ram_addr    (addr[g]),
         .ram_wr_data (wr_data[g]),
         .ram_rd_data (rd_data[g]),
         .busy        (busy[g]),
         .done        (done[g]),
         .err         (err[g]),
         .err_cnt     (err_cnt[g]),
         .err_addr    (err_addr[g])
      );

      always @(posedge clk) begin
         if (wr_en[g]) mem[addr[g]] <= wr_data[g];
         pipe[0] <= rdfn(mem[addr[g]], fault[g], addr[g]);
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
         pipe[3] <= pipe[2];
      end
      assign rd_data[g] = pipe[mlat[g]-1];

      always @(negedge clk) begin
         if (!rst_n[g]) begin
            bcnt = 0;
            ovl  = 1'b0;
         end else begin
            if (busy[g]) bcnt++;
            if (wr_en[g]) lastw[addr[g]] = wr_data[g];
            if ((wr_en[g] && rd_en[g]) ||
                (!wr_en[g] && !rd_en[g] &&
                 (addr[g] != 0 || wr_data[g] != 0)))
               ovl = 1'b1;
            if (done[g]) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("i%0d_unexpected_done", g), 1, 0);
               end else begin
                  r = exp_q.pop_front();
                  chk($sformatf("i%0d_done_busy_cycle", g),
                      bcnt, r.busy);
                  chk($sformatf("i%0d_wdata_a%0d", g, r.addr),
                      lastw[r.addr], r.data);
                  chk($sformatf("i%0d_err", g), err[g], r.err);
                  if (r.gt0)
                     chk($sformatf("i%0d_errcnt_nonzero", g),
                         err_cnt[g] != 0, 1);
                  else
                     chk($sformatf("i%0d_errcnt", g),
                         err_cnt[g], r.cnt);
                  chk($sformatf("i%0d_erraddr", g),
                      err_addr[g], r.eaddr);
                  chk($sformatf("i%0d_bus_rules", g), ovl, 0);
               end
               bcnt = 0;
               ovl  = 1'b0;
            end
         end
      end
   end

   function automatic int qsize(input int g);
      if (g == 0) return gi[0].exp_q.size();
      return gi[1].exp_q.size();
   endfunction

   function automatic logic [63:0] outs(input int g);
      return {25'd0, wr_en[g], rd_en[g], addr[g], wr_data[g],
              busy[g], done[g], err[g], err_cnt[g],
              err_addr[g]};
   endfunction

   task automatic run(input int g, input logic [1:0] m,
                      input logic [7:0] s, input int f,
                      input int ml, input int ca,
                      input logic [7:0] cd, input logic e,
                      input int cnt, input logic gt0,
                      input int ea, input int bz,
                      input int mid);
      run_t x;
      x.addr = ca; x.data = cd; x.err = e; x.cnt = cnt;
      x.gt0 = gt0; x.eaddr = ea; x.busy = bz;
      fault[g] = f;
      mlat[g]  = ml;
      if (g == 0) gi[0].exp_q.push_back(x);
      else        gi[1].exp_q.push_back(x);
      @(negedge clk);
      mode[g] = m; seed[g] = s; start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0; mode[g] = ~m; seed[g] = ~s;
      if (mid > 0) begin
         repeat (mid) @(negedge clk);
         start[g] = 1'b1;
         @(negedge clk);
         start[g] = 1'b0;
      end
      for (int n = 0; n < 300; n++) begin
         if (qsize(g) == 0) break;
         @(negedge clk);
      end
      chk($sformatf("i%0d_run_timeout", g), qsize(g), 0);
      repeat (3) @(negedge clk);
      chk($sformatf("i%0d_idle_after_run", g), busy[g], 0);
      if (!gt0)
         chk($sformatf("i%0d_errcnt_hold", g), err_cnt[g], cnt);
   endtask

   initial begin
      logic acc;
      for (int g = 0; g < 2; g++) begin
         rst_n[g] = 1'b0; start[g] = 1'b0;
         mode[g] = 2'd0; seed[g] = 8'd0;
         fault[g] = 0; mlat[g] = 1;
      end
      repeat (3) @(negedge clk);
      chk("i0_reset_outputs", outs(0), 0);
      chk("i1_reset_outputs", outs(1), 0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      @(negedge clk);

      run(0, 2'd0, 8'h10, 0, 1, 31, 8'h2F, 0, 0, 0, 0, 66, 0);
      run(0, 2'd1, 8'h00, 1, 1, 5, 8'h00, 1, 1, 0, 5, 66, 0);
      run(0, 2'd2, 8'hA5, 0, 1, 9, 8'h02, 0, 0, 0, 0, 66, 0);
      run(0, 2'd3, 8'hA5, 0, 1, 9, 8'h5A, 0, 0, 0, 0, 66, 0);
      run(0, 2'd1, 8'h00, 2, 1, 0, 8'h00, 1, 32, 0, 0, 66, 0);
      run(0, 2'd0, 8'h00, 0, 1, 31, 8'h1F, 0, 0, 0, 0, 66, 20);

      // Abort a run with reset at write address 10.
      @(negedge clk);
      mode[0] = 2'd0; seed[0] = 8'h00; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (wr_en[0] && addr[0] == 5'd10) break;
         @(negedge clk);
      end
      chk("abort_reach_addr10", {wr_en[0], addr[0]}, {1'b1, 5'd10});
      rst_n[0] = 1'b0;
      @(negedge clk);
      chk("abort_reset_outputs", outs(0), 0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         acc = acc | wr_en[0] | rd_en[0] | busy[0] | done[0];
      end
      chk("abort_no_activity", acc, 0);

      run(0, 2'd3, 8'h3C, 0, 1, 1, 8'hC3, 0, 0, 0, 0, 66, 0);

      run(1, 2'd0, 8'h10, 0, 3, 31, 8'h2F, 0, 0, 0, 0, 68, 0);
      run(1, 2'd0, 8'h10, 0, 1, 31, 8'h2F, 1, 0, 1, 0, 68, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
